// File: rtl/ysyx_23060191_mem_arbiter.sv
// rtl/ysyx_23060191_mem_arbiter.sv - IFU/LSU arbiter in front of a single memory port
//
// Purpose:
//   The instruction-fetch and load/store requesters share one memory port
//   through this block. Only one transaction is outstanding at a time. The
//   accepted request is registered and driven to memory. The response is
//   steered back to the requester that owns the transaction.
//
// Ports:
//   clk, rstn                       clock; synchronous active-high reset (1 = reset)
//   ifu_req_valid/ready, ifu_addr   fetch request handshake and address
//   ifu_rsp_valid, ifu_rdata        one-cycle fetch response pulse and held data
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wmask   load/store request handshake and fields
//   lsu_rsp_valid, lsu_rdata        one-cycle load/store response pulse and held data
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask   registered request to memory
//   mem_rsp_valid, mem_rdata        memory response
//
// Configuration:
//   YSYX_23060191_ARB_RR_EN  defined: round-robin between IFU and LSU.
//                            undefined: fixed priority, LSU over IFU.

module ysyx_23060191_mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            ifu_req_valid,
   output logic            ifu_req_ready,
   input  logic [AW-1:0]   ifu_addr,
   output logic            ifu_rsp_valid,
   output logic [DW-1:0]   ifu_rdata,
   input  logic            lsu_req_valid,
   output logic            lsu_req_ready,
   input  logic [AW-1:0]   lsu_addr,
   input  logic            lsu_wen,
   input  logic [DW-1:0]   lsu_wdata,
   input  logic [DW/8-1:0] lsu_wmask,
   output logic            lsu_rsp_valid,
   output logic [DW-1:0]   lsu_rdata,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_wen,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wmask,
   input  logic            mem_rsp_valid,
   input  logic [DW-1:0]   mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   // 1 = the outstanding transaction belongs to the LSU, 0 = IFU
   logic owner_lsu;
   logic grant_lsu;

`ifdef YSYX_23060191_ARB_RR_EN
   // 1 = the LSU received the most recent grant, 0 = IFU
   logic last_grant_lsu;
`endif

   always_comb begin
`ifdef YSYX_23060191_ARB_RR_EN
      // On contention the requester that did not win last time is chosen
      grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_grant_lsu);
`else
      grant_lsu = lsu_req_valid;
`endif
   end

   always_comb begin
      next_state    = state;
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      case (state)
         IDLE: begin
            // No grant while reset is asserted, so readies read 0 during reset
            if (!rstn && (ifu_req_valid || lsu_req_valid)) begin
               lsu_req_ready = grant_lsu;
               ifu_req_ready = !grant_lsu;
               next_state    = REQ;
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         state          <= IDLE;
         owner_lsu      <= 1'b0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         ifu_rsp_valid  <= 1'b0;
         lsu_rsp_valid  <= 1'b0;
         ifu_rdata      <= '0;
         lsu_rdata      <= '0;
`ifdef YSYX_23060191_ARB_RR_EN
         last_grant_lsu <= 1'b0;
`endif
      end else begin
         state         <= next_state;
         ifu_rsp_valid <= 1'b0;
         lsu_rsp_valid <= 1'b0;

         if (lsu_req_ready) begin
            owner_lsu <= 1'b1;
            mem_addr  <= lsu_addr;
            mem_wen   <= lsu_wen;
            mem_wdata <= lsu_wdata;
            mem_wmask <= lsu_wmask;
         end else if (ifu_req_ready) begin
            // Fetches are always full-width reads
            owner_lsu <= 1'b0;
            mem_addr  <= ifu_addr;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '1;
         end

`ifdef YSYX_23060191_ARB_RR_EN
         if (lsu_req_ready || ifu_req_ready) begin
            last_grant_lsu <= lsu_req_ready;
         end
`endif

         // Responses count only in WAIT; strays in IDLE/REQ are dropped
         if (state == WAIT && mem_rsp_valid) begin
            if (owner_lsu) begin
               lsu_rsp_valid <= 1'b1;
               lsu_rdata     <= mem_rdata;
            end else begin
               ifu_rsp_valid <= 1'b1;
               ifu_rdata     <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// tb/tb_ysyx_23060191_mem_arbiter.sv - directed vector bench for ysyx_23060191_mem_arbiter

module tb_ysyx_23060191_mem_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   always #5 clk = ~clk;

   ysyx_23060191_mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rstn(rstn),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      // inputs applied during the cycle
      logic        rst;
      logic        iv;
      logic [31:0] ia;
      logic        lv;
      logic        lw;
      logic [31:0] la;
      logic [31:0] wd;
      logic [3:0]  wm;
      logic        mrdy;
      logic        mrsp;
      logic [31:0] mrd;
      // outputs expected during the same cycle
      logic        e_ir;
      logic        e_lr;
      logic        e_mv;
      logic [31:0] e_ma;
      logic        e_mw;
      logic [31:0] e_md;
      logic [3:0]  e_mm;
      logic        e_is;
      logic [31:0] e_id;
      logic        e_ls;
      logic [31:0] e_ld;
   } vec_t;

   vec_t vecs[30];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic rst, input logic iv, input logic [31:0] ia,
      input logic lv, input logic lw, input logic [31:0] la, input logic [31:0] wd,
      input logic [3:0] wm, input logic mrdy, input logic mrsp, input logic [31:0] mrd,
      input logic e_ir, input logic e_lr, input logic e_mv, input logic [31:0] e_ma,
      input logic e_mw, input logic [31:0] e_md, input logic [3:0] e_mm,
      input logic e_is, input logic [31:0] e_id, input logic e_ls, input logic [31:0] e_ld);
      vec_t v;
      v.rst = rst; v.iv = iv; v.ia = ia; v.lv = lv; v.lw = lw; v.la = la; v.wd = wd;
      v.wm = wm; v.mrdy = mrdy; v.mrsp = mrsp; v.mrd = mrd;
      v.e_ir = e_ir; v.e_lr = e_lr; v.e_mv = e_mv; v.e_ma = e_ma; v.e_mw = e_mw;
      v.e_md = e_md; v.e_mm = e_mm; v.e_is = e_is; v.e_id = e_id; v.e_ls = e_ls; v.e_ld = e_ld;
      return v;
   endfunction

   localparam logic [31:0] FA = 32'h8000_0000;
   localparam logic [31:0] SA = 32'h8000_1000;
   localparam logic [31:0] BE = 32'hDEAD_BEEF;
   localparam logic [31:0] I1 = 32'h0010_0073;
   localparam logic [31:0] L1 = 32'hCAFE_F00D;
   localparam logic [31:0] KEY = 32'h5A5A_A5A5;

`ifdef YSYX_23060191_ARB_RR_EN
   localparam int NCON = 4;
   logic exp_order[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
   localparam int NCON = 2;
   logic exp_order[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif

   initial begin
      //            rst iv ia            lv lw la            wd     wm    rdy rsp mrd
      //            ir lr mv ma          mw md     mm    is id            ls ld
      // idle after reset: everything zero
      vecs[0]  = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,0,            0,0,   4'h0, 0,0,            0,0);
      // single fetch
      vecs[1]  = mk(0,1,FA,          0,0,0,           0,   4'h0, 1,0,0,
                    1,0,0,0,            0,0,   4'h0, 0,0,            0,0);
      vecs[2]  = mk(0,0,0,           0,0,0,           0,   4'h0, 1,0,0,
                    0,0,1,FA,           0,0,   4'hF, 0,0,            0,0);
      vecs[3]  = mk(0,0,0,           0,0,0,           0,   4'h0, 0,1,I1,
                    0,0,0,FA,           0,0,   4'hF, 0,0,            0,0);
      vecs[4]  = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,FA,           0,0,   4'hF, 1,I1,           0,0);
      vecs[5]  = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,FA,           0,0,   4'hF, 0,I1,           0,0);
      // store, memory stalls 3 cycles; lsu inputs change after acceptance
      vecs[6]  = mk(0,0,0,           1,1,SA,          BE,  4'h3, 0,0,0,
                    0,1,0,FA,           0,0,   4'hF, 0,I1,           0,0);
      vecs[7]  = mk(0,0,0,           0,0,32'h1234_5678,32'h1,4'hC,0,0,0,
                    0,0,1,SA,           1,BE,  4'h3, 0,I1,           0,0);
      vecs[8]  = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,1,SA,           1,BE,  4'h3, 0,I1,           0,0);
      vecs[9]  = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,1,SA,           1,BE,  4'h3, 0,I1,           0,0);
      vecs[10] = mk(0,0,0,           0,0,0,           0,   4'h0, 1,0,0,
                    0,0,1,SA,           1,BE,  4'h3, 0,I1,           0,0);
      vecs[11] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,1,L1,
                    0,0,0,SA,           1,BE,  4'h3, 0,I1,           0,0);
      vecs[12] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,SA,           1,BE,  4'h3, 0,I1,           1,L1);
      vecs[13] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,SA,           1,BE,  4'h3, 0,I1,           0,L1);
      // stray responses: in IDLE, at grant, and together with mem_req_ready
      vecs[14] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,1,32'h1111_1111,
                    0,0,0,SA,           1,BE,  4'h3, 0,I1,           0,L1);
      vecs[15] = mk(0,1,FA+4,        0,0,0,           0,   4'h0, 0,1,32'h1111_1111,
                    1,0,0,SA,           1,BE,  4'h3, 0,I1,           0,L1);
      vecs[16] = mk(0,0,0,           0,0,0,           0,   4'h0, 1,1,32'h2222_2222,
                    0,0,1,FA+4,         0,0,   4'hF, 0,I1,           0,L1);
      vecs[17] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,FA+4,         0,0,   4'hF, 0,I1,           0,L1);
      vecs[18] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,1,32'h3333_3333,
                    0,0,0,FA+4,         0,0,   4'hF, 0,I1,           0,L1);
      vecs[19] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,FA+4,         0,0,   4'hF, 1,32'h3333_3333,0,L1);
      vecs[20] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,FA+4,         0,0,   4'hF, 0,32'h3333_3333,0,L1);
      // reset in WAIT, late response, then a normal fetch
      vecs[21] = mk(0,0,0,           1,0,32'h8000_2000,0,  4'hF, 0,0,0,
                    0,1,0,FA+4,         0,0,   4'hF, 0,32'h3333_3333,0,L1);
      vecs[22] = mk(0,0,0,           0,0,0,           0,   4'h0, 1,0,0,
                    0,0,1,32'h8000_2000,0,0,   4'hF, 0,32'h3333_3333,0,L1);
      vecs[23] = mk(1,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,32'h8000_2000,0,0,   4'hF, 0,32'h3333_3333,0,L1);
      vecs[24] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,1,32'h4444_4444,
                    0,0,0,0,            0,0,   4'h0, 0,0,            0,0);
      vecs[25] = mk(0,1,FA+8,        0,0,0,           0,   4'h0, 0,0,0,
                    1,0,0,0,            0,0,   4'h0, 0,0,            0,0);
      vecs[26] = mk(0,0,0,           0,0,0,           0,   4'h0, 1,0,0,
                    0,0,1,FA+8,         0,0,   4'hF, 0,0,            0,0);
      vecs[27] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,1,32'h5555_5555,
                    0,0,0,FA+8,         0,0,   4'hF, 0,0,            0,0);
      vecs[28] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,FA+8,         0,0,   4'hF, 1,32'h5555_5555,0,0);
      vecs[29] = mk(0,0,0,           0,0,0,           0,   4'h0, 0,0,0,
                    0,0,0,FA+8,         0,0,   4'hF, 0,32'h5555_5555,0,0);

      rstn = 1'b1;
      ifu_req_valid = 0; ifu_addr = 0;
      lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 30; i++) begin
         rstn          = vecs[i].rst;
         ifu_req_valid = vecs[i].iv;
         ifu_addr      = vecs[i].ia;
         lsu_req_valid = vecs[i].lv;
         lsu_wen       = vecs[i].lw;
         lsu_addr      = vecs[i].la;
         lsu_wdata     = vecs[i].wd;
         lsu_wmask     = vecs[i].wm;
         mem_req_ready = vecs[i].mrdy;
         mem_rsp_valid = vecs[i].mrsp;
         mem_rdata     = vecs[i].mrd;
         #1;
         chk($sformatf("v%0d ifu_req_ready", i), {31'b0, ifu_req_ready}, {31'b0, vecs[i].e_ir});
         chk($sformatf("v%0d lsu_req_ready", i), {31'b0, lsu_req_ready}, {31'b0, vecs[i].e_lr});
         chk($sformatf("v%0d mem_req_valid", i), {31'b0, mem_req_valid}, {31'b0, vecs[i].e_mv});
         chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_ma);
         chk($sformatf("v%0d mem_wen", i), {31'b0, mem_wen}, {31'b0, vecs[i].e_mw});
         chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_md);
         chk($sformatf("v%0d mem_wmask", i), {28'b0, mem_wmask}, {28'b0, vecs[i].e_mm});
         chk($sformatf("v%0d ifu_rsp_valid", i), {31'b0, ifu_rsp_valid}, {31'b0, vecs[i].e_is});
         chk($sformatf("v%0d ifu_rdata", i), ifu_rdata, vecs[i].e_id);
         chk($sformatf("v%0d lsu_rsp_valid", i), {31'b0, lsu_rsp_valid}, {31'b0, vecs[i].e_ls});
         chk($sformatf("v%0d lsu_rdata", i), lsu_rdata, vecs[i].e_ld);
         @(posedge clk);
         #1;
      end

      // contention: both requesters valid in IDLE
      rstn = 1'b0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
      ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
      lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_3000; lsu_wdata = 0; lsu_wmask = 4'hF;
      for (int t = 0; t < NCON; t++) begin
         logic granted;
         logic g_lsu;
         int   cyc;
         granted = 1'b0;
         g_lsu   = 1'b0;
         cyc     = 0;
         while (!granted && cyc < 8) begin
            #1;
            if (ifu_req_ready || lsu_req_ready) begin
               granted = 1'b1;
               g_lsu   = lsu_req_ready;
               chk($sformatf("c%0d single grant", t), {31'b0, ifu_req_ready & lsu_req_ready}, 32'd0);
            end else begin
               @(posedge clk);
               #1;
               cyc++;
            end
         end
         chk($sformatf("c%0d grant seen", t), {31'b0, granted}, 32'd1);
         chk($sformatf("c%0d grant lsu", t), {31'b0, g_lsu}, {31'b0, exp_order[t]});
         @(posedge clk);
         #1;
`ifndef YSYX_23060191_ARB_RR_EN
         if (g_lsu) lsu_req_valid = 0;
         else       ifu_req_valid = 0;
`endif
         chk($sformatf("c%0d mem_req_valid", t), {31'b0, mem_req_valid}, 32'd1);
         chk($sformatf("c%0d mem_addr", t), mem_addr, g_lsu ? 32'h8000_3000 : 32'h8000_0100);
         mem_req_ready = 1;
         @(posedge clk);
         #1;
         mem_req_ready = 0;
         mem_rsp_valid = 1;
         mem_rdata     = mem_addr ^ KEY;
         @(posedge clk);
         #1;
         mem_rsp_valid = 0;
         chk($sformatf("c%0d ifu_rsp_valid", t), {31'b0, ifu_rsp_valid}, {31'b0, !g_lsu});
         chk($sformatf("c%0d lsu_rsp_valid", t), {31'b0, lsu_rsp_valid}, {31'b0, g_lsu});
         if (g_lsu) chk($sformatf("c%0d lsu_rdata", t), lsu_rdata, 32'h8000_3000 ^ KEY);
         else       chk($sformatf("c%0d ifu_rdata", t), ifu_rdata, 32'h8000_0100 ^ KEY);
      end
      ifu_req_valid = 0;
      lsu_req_valid = 0;
      #1;
      chk("end ifu_req_ready", {31'b0, ifu_req_ready}, 32'd0);
      chk("end lsu_req_ready", {31'b0, lsu_req_ready}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
